risc_controller: RTL

Instruction register, decoder and Moore control FSM for the 16-bit datapath that contains the ALU. It issues operand reads, ALUop, and the load, select and write strobes that the ALU datapath consumes. It also latches the 3-bit ALU status {V,N,Z} on CMP. It is the initiator and consumer side of the ALU's ALUop/status interface.

---
 rtl/risc_controller.sv | 84 ++++++++
 1 files changed

// File: rtl/risc_controller.sv
// risc_controller: instruction register, decoder and Moore control FSM for the 16-bit ALU datapath
module risc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  input  logic [2:0]  status_in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic [2:0]  status
);
  typedef enum logic [2:0] {S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_WRITE_IMM} state_t;
  state_t state, ns;
  logic [15:0] ir, ir_n;
  logic [2:0] opc;
  logic [1:0] op;
  logic mov_imm, mov_reg, alu, cmp;
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign shift = (ir[15:13] == 3'b101 || ir[15:11] == 5'b11000) ? ir[4:3] : 2'b00;
  assign bsel = 1'b0;
  always_comb begin
    ir_n = (state == S_WAIT && load) ? in : ir;
    opc = ir_n[15:13];
    op = ir_n[12:11];
    mov_imm = opc == 3'b110 && op == 2'b10;
    mov_reg = opc == 3'b110 && op == 2'b00;
    alu = opc == 3'b101;
    cmp = alu && op == 2'b01;
    ns = S_WAIT;
    case (state)
      S_WAIT:   ns = s ? S_DECODE : S_WAIT;
      S_DECODE: ns = mov_imm ? S_WRITE_IMM : (alu && op != 2'b11) ? S_GET_A : (mov_reg || alu) ? S_GET_B : S_WAIT;
      S_GET_A:  ns = S_GET_B;
      S_GET_B:  ns = S_EXEC;
      S_EXEC:   ns = cmp ? S_WAIT : S_WRITE_REG;
      default:  ns = S_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir <= '0;
      status <= '0;
      w <= 1'b1;
      readnum <= '0;
      writenum <= '0;
      write <= 1'b0;
      loada <= 1'b0;
      loadb <= 1'b0;
      loadc <= 1'b0;
      asel <= 1'b0;
      vsel <= '0;
      ALUop <= '0;
    end else begin
      state <= ns;
      ir <= ir_n;
      if (state == S_EXEC && cmp) status <= status_in;
      w <= ns == S_WAIT;
      readnum <= ns == S_GET_A ? ir_n[10:8] : ns == S_GET_B ? ir_n[2:0] : 3'b000;
      writenum <= ns == S_WRITE_REG ? ir_n[7:5] : ns == S_WRITE_IMM ? ir_n[10:8] : 3'b000;
      write <= ns == S_WRITE_REG || ns == S_WRITE_IMM;
      loada <= ns == S_GET_A;
      loadb <= ns == S_GET_B;
      loadc <= ns == S_EXEC && !cmp;
      asel <= ns == S_EXEC && mov_reg;
      vsel <= ns == S_WRITE_IMM ? 2'b10 : 2'b00;
      ALUop <= (ns == S_EXEC && alu) ? op : 2'b00;
    end
  end
endmodule
